jtpang_pcm_rom: RTL and testbench

- Fetch adapter between the MSM6295-class PCM decoder's byte ROM port and the shared SDRAM slot.
- The decoder issues 18-bit byte addresses and waits on an ok flag. This block serves reads from a small fully-associative cache of 16-bit words.
- On a miss it issues a single-word SDRAM request with a req/ack/dok handshake.
- It sits directly upstream of the sound block's ROM interface, so that ADPCM nibble fetches hide SDRAM arbitration latency.

---
 rtl/jtpang_pcm_rom_if.sv | 37 +++
 rtl/jtpang_pcm_rom.sv | 134 +++++++++++++
 tb/tb_jtpang_pcm_rom.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_pcm_rom_if.sv
// rtl/jtpang_pcm_rom_if.sv - PCM byte port and SDRAM word port of the PCM ROM fetch adapter
interface jtpang_pcm_rom_if #(
  parameter int AW = 18
);
  logic [AW-1:0] pcm_addr;
  logic [7:0]    pcm_data;
  logic          pcm_ok;
  logic [AW-2:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          sdram_dok;
  logic [15:0]   sdram_data;

  // master: the fetch adapter (serves the decoder, requests from SDRAM)
  modport master (
    input  pcm_addr,
    output pcm_data,
    output pcm_ok,
    output sdram_addr,
    output sdram_req,
    input  sdram_ack,
    input  sdram_dok,
    input  sdram_data
  );

  // slave: decoder plus SDRAM slot seen from the outside
  modport slave (
    output pcm_addr,
    input  pcm_data,
    input  pcm_ok,
    input  sdram_addr,
    input  sdram_req,
    output sdram_ack,
    output sdram_dok,
    output sdram_data
  );
endinterface

// File: rtl/jtpang_pcm_rom.sv
// rtl/jtpang_pcm_rom.sv - PCM byte ROM port served from a small word cache over SDRAM
module jtpang_pcm_rom #(
  parameter int LINES = 4,
  parameter int AW    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  jtpang_pcm_rom_if.master bus
);
  localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state, state_nx;
  logic [AW-2:0]    tag  [LINES];
  logic [15:0]      data [LINES];
  logic [LINES-1:0] valid;
  logic [IW-1:0]    rr;

  logic [AW-2:0]    word_addr;
  logic [LINES-1:0] match;
  logic             any_match;
  logic [15:0]      match_word;

  logic             hit_r;
  logic [15:0]      word_r;
  logic [AW-1:0]    addr_l;

  logic             drop, drop_nx;
  logic             req_nx;
  logic [AW-2:0]    addr_nx;
  logic             fill;

  assign word_addr = bus.pcm_addr[AW-1:1];
  assign any_match = |match;

  // tag compare; scanning from the top lets the lowest matching index win
  always_comb begin
    match      = '0;
    match_word = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      match[i] = valid[i] && (tag[i] == word_addr);
      if (match[i]) match_word = data[i];
    end
  end

  // hit pipeline: registered hit/word plus the address they belong to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_r  <= 1'b0;
      word_r <= '0;
      addr_l <= '0;
    end else begin
      hit_r  <= any_match && !flush;
      word_r <= match_word;
      addr_l <= bus.pcm_addr;
    end
  end

  // ok drops the moment the decoder moves away from the latched address
  assign bus.pcm_ok   = hit_r && (addr_l == bus.pcm_addr);
  assign bus.pcm_data = addr_l[0] ? word_r[15:8] : word_r[7:0];

  // fetch FSM next state; a flush seen while a fetch is in flight marks its
  // data as belonging to the old bank, so the eventual dok is discarded
  always_comb begin
    state_nx = state;
    req_nx   = bus.sdram_req;
    addr_nx  = bus.sdram_addr;
    drop_nx  = drop;
    fill     = 1'b0;
    case (state)
      IDLE: begin
        drop_nx = 1'b0;
        if (!any_match && !flush) begin
          state_nx = REQ;
          req_nx   = 1'b1;
          addr_nx  = word_addr;
        end
      end
      REQ: begin
        if (flush) drop_nx = 1'b1;
        if (bus.sdram_ack) begin
          req_nx = 1'b0;
          if (bus.sdram_dok) begin
            fill     = !(drop || flush);
            state_nx = IDLE;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) drop_nx = 1'b1;
        if (bus.sdram_dok) begin
          fill     = !(drop || flush);
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // fetch FSM state and SDRAM request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.sdram_req  <= 1'b0;
      bus.sdram_addr <= '0;
      drop           <= 1'b0;
    end else begin
      state          <= state_nx;
      bus.sdram_req  <= req_nx;
      bus.sdram_addr <= addr_nx;
      drop           <= drop_nx;
    end
  end

  // cache fill with round-robin replacement; flush only touches valid bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      rr    <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[rr] <= 1'b1;
      tag[rr]   <= bus.sdram_addr;
      data[rr]  <= bus.sdram_data;
      rr        <= (LINES == 1) ? '0 : rr + IW'(1);
    end
  end
endmodule

// File: tb/tb_jtpang_pcm_rom.sv
// tb/tb_jtpang_pcm_rom.sv - self-checking bench for jtpang_pcm_rom
module tb_jtpang_pcm_rom;
  localparam int LINES = 4;
  localparam int AW    = 18;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  jtpang_pcm_rom_if #(.AW(AW)) ifc ();

  jtpang_pcm_rom #(.LINES(LINES), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model of the cache contents: words currently held, oldest first
  logic [16:0] mq[$];
  logic        prev_inq, prev_flush, exp_ok, push;
  logic [17:0] prev_addr;
  logic [16:0] req_word, w;
  logic        req_seen;
  int          rph, wa, wd, hold, n_hits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mword(input logic [16:0] a);
    return {a[7:0] ^ 8'hA5, a[7:0] + 8'h3C};
  endfunction

  function automatic logic in_q(input logic [16:0] a);
    foreach (mq[i]) if (mq[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // point the decoder at a missing word, serve it, expect the low byte
  task automatic fetch(input logic [16:0] a, input logic [15:0] d, input string tag);
    int n;
    n = 0;
    ifc.pcm_addr = {a, 1'b0};
    step();
    while (!ifc.sdram_req && n < 8) begin
      step();
      n++;
    end
    check({tag, "_req"}, ifc.sdram_req, 1);
    check({tag, "_addr"}, ifc.sdram_addr, a);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = d;
    step();
    ifc.sdram_dok = 1'b0;
    step();
    check({tag, "_ok"}, ifc.pcm_ok, 1);
    check({tag, "_data"}, ifc.pcm_data, d[7:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ifc.pcm_addr   = 18'h00010;
    ifc.sdram_ack  = 1'b0;
    ifc.sdram_dok  = 1'b0;
    ifc.sdram_data = '0;
    step();
    step();
    check("rst_ok", ifc.pcm_ok, 0);
    check("rst_data", ifc.pcm_data, 0);
    check("rst_req", ifc.sdram_req, 0);
    check("rst_addr", ifc.sdram_addr, 0);

    // first miss after reset
    rst_n = 1'b1;
    step();
    check("t1_req", ifc.sdram_req, 1);
    check("t1_addr", ifc.sdram_addr, 17'h00008);
    step();
    check("t1_req_hold", ifc.sdram_req, 1);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    check("t1_req_drop", ifc.sdram_req, 0);
    step();
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'hBEEF;
    step();
    ifc.sdram_dok = 1'b0;
    check("t1_ok_n1", ifc.pcm_ok, 0);
    step();
    check("t1_ok_n2", ifc.pcm_ok, 1);
    check("t1_data", ifc.pcm_data, 8'hEF);
    check("t1_no_req", ifc.sdram_req, 0);

    // other byte of the same word
    ifc.pcm_addr = 18'h00011;
    #1;
    check("t2_ok_drop", ifc.pcm_ok, 0);
    step();
    check("t2_ok", ifc.pcm_ok, 1);
    check("t2_data", ifc.pcm_data, 8'hBE);
    check("t2_no_req", ifc.sdram_req, 0);

    // five fills through four lines: oldest words are evicted
    for (int i = 0; i < 5; i++) fetch(17'(i), 16'h1000 + 16'(i), $sformatf("t3_fill%0d", i));
    for (int i = 1; i < 4; i++) begin
      ifc.pcm_addr = {17'(i), 1'b0};
      step();
      check($sformatf("t3_hit%0d_ok", i), ifc.pcm_ok, 1);
      check($sformatf("t3_hit%0d_data", i), ifc.pcm_data, 8'(i));
      check($sformatf("t3_hit%0d_req", i), ifc.sdram_req, 0);
    end
    fetch(17'd0, 16'h1000, "t3_w0_again");

    // address moves while the fetch is in WAIT
    ifc.pcm_addr = 18'h00100;
    step();
    check("t4_req", ifc.sdram_req, 1);
    check("t4_addr", ifc.sdram_addr, 17'h00080);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.pcm_addr = 18'h00200;
    step();
    check("t4_ok_wait", ifc.pcm_ok, 0);
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'h1111;
    step();
    ifc.sdram_dok = 1'b0;
    check("t4_ok_fill1", ifc.pcm_ok, 0);
    step();
    check("t4_req2", ifc.sdram_req, 1);
    check("t4_addr2", ifc.sdram_addr, 17'h00100);
    check("t4_ok_req2", ifc.pcm_ok, 0);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'h2222;
    step();
    ifc.sdram_dok = 1'b0;
    check("t4_ok_fill2", ifc.pcm_ok, 0);
    step();
    check("t4_ok", ifc.pcm_ok, 1);
    check("t4_data", ifc.pcm_data, 8'h22);
    ifc.pcm_addr = 18'h00101;
    step();
    check("t4_first_ok", ifc.pcm_ok, 1);
    check("t4_first_data", ifc.pcm_data, 8'h11);

    // flush coincident with dok
    ifc.pcm_addr = 18'h00300;
    step();
    check("t5_req", ifc.sdram_req, 1);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'h3333;
    flush = 1'b1;
    step();
    ifc.sdram_dok = 1'b0;
    flush = 1'b0;
    check("t5_ok_after_flush", ifc.pcm_ok, 0);
    step();
    check("t5_rereq", ifc.sdram_req, 1);
    check("t5_rereq_addr", ifc.sdram_addr, 17'h00180);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'h3434;
    step();
    ifc.sdram_dok = 1'b0;
    step();
    check("t5_ok", ifc.pcm_ok, 1);
    check("t5_data", ifc.pcm_data, 8'h34);
    // flush in IDLE on a hitting address
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_idle_flush_ok", ifc.pcm_ok, 0);
    check("t5_idle_flush_req", ifc.sdram_req, 0);
    step();
    check("t5_post_flush_req", ifc.sdram_req, 1);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'h3535;
    step();
    ifc.sdram_dok = 1'b0;
    step();
    check("t5_refill_data", ifc.pcm_data, 8'h35);

    // reset in REQ, then a stray dok
    ifc.pcm_addr = 18'h00400;
    step();
    check("t6_req", ifc.sdram_req, 1);
    rst_n = 1'b0;
    step();
    check("t6_rst_req", ifc.sdram_req, 0);
    check("t6_rst_ok", ifc.pcm_ok, 0);
    rst_n = 1'b1;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'hDEAD;
    step();
    ifc.sdram_dok = 1'b0;
    check("t6_stray_ok", ifc.pcm_ok, 0);
    check("t6_new_req", ifc.sdram_req, 1);
    step();
    check("t6_stray_ok2", ifc.pcm_ok, 0);
    ifc.sdram_ack = 1'b1;
    step();
    ifc.sdram_ack = 1'b0;
    ifc.sdram_dok = 1'b1;
    ifc.sdram_data = 16'h4444;
    step();
    ifc.sdram_dok = 1'b0;
    step();
    check("t6_ok", ifc.pcm_ok, 1);
    check("t6_data", ifc.pcm_data, 8'h44);

    // randomized traffic against the cache model
    flush = 1'b1;
    prev_flush = 1'b1;
    prev_inq = 1'b0;
    prev_addr = ifc.pcm_addr;
    mq.delete();
    rph = 0;
    req_seen = 1'b0;
    hold = 0;
    n_hits = 0;
    req_word = '0;
    for (int it = 0; it < 3000; it++) begin
      step();
      flush = 1'b0;
      ifc.sdram_ack = 1'b0;
      ifc.sdram_dok = 1'b0;
      push = 1'b0;
      if (ifc.sdram_req) begin
        if (!req_seen) begin
          check("rnd_req_addr", ifc.sdram_addr, prev_addr[17:1]);
          check("rnd_req_miss", prev_inq | prev_flush, 0);
          req_seen = 1'b1;
          req_word = ifc.sdram_addr;
        end else begin
          check("rnd_req_hold", ifc.sdram_addr, req_word);
        end
      end
      if (rph == 0 && !ifc.sdram_req && $urandom_range(0, 29) == 0) flush = 1'b1;
      case (rph)
        0: if (ifc.sdram_req) begin
          wa = $urandom_range(0, 2);
          rph = 1;
        end
        1: if (wa == 0) begin
          ifc.sdram_ack = 1'b1;
          req_seen = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            ifc.sdram_dok = 1'b1;
            ifc.sdram_data = mword(req_word);
            push = 1'b1;
            rph = 0;
          end else begin
            wd = $urandom_range(0, 3);
            rph = 2;
          end
        end else wa--;
        default: if (wd == 0) begin
          ifc.sdram_dok = 1'b1;
          ifc.sdram_data = mword(req_word);
          push = 1'b1;
          rph = 0;
        end else wd--;
      endcase
      if (hold == 0) begin
        ifc.pcm_addr = {17'h00040 + 17'($urandom_range(0, 5)), 1'($urandom_range(0, 1))};
        hold = $urandom_range(0, 6);
      end else begin
        hold--;
        if ($urandom_range(0, 7) == 0) ifc.pcm_addr[0] = ~ifc.pcm_addr[0];
      end
      #1;
      w = ifc.pcm_addr[17:1];
      exp_ok = prev_inq && (prev_addr == ifc.pcm_addr) && !prev_flush;
      check("rnd_ok", ifc.pcm_ok, exp_ok);
      if (exp_ok) begin
        n_hits++;
        check("rnd_data", ifc.pcm_data, ifc.pcm_addr[0] ? mword(w)[15:8] : mword(w)[7:0]);
      end
      prev_inq = in_q(w);
      prev_addr = ifc.pcm_addr;
      prev_flush = flush;
      if (flush) mq.delete();
      if (push) begin
        mq.push_back(req_word);
        if (mq.size() > LINES) void'(mq.pop_front());
      end
    end
    check("rnd_hits_seen", 32'(n_hits > 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
